stage_cmd_seq: RTL and testbench

//  Upstream command sequencer for the EKF-SLAM top level. Buffers stage commands from the PS side
//  (stage code plus two 32-bit operands) in a small FIFO and replays them one at a time on the

---
 rtl/ekf_stage_pkg.sv | 24 ++
 rtl/cmd_fifo.sv | 54 +++++
 rtl/stage_cmd_seq.sv | 158 +++++++++++++++
 tb/tb_stage_cmd_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ekf_stage_pkg.sv
// ekf_stage_pkg: shared stage codes and FSM encodings
// for the EKF-SLAM upstream command sequencer.
package ekf_stage_pkg;

  localparam logic [2:0] STAGE_IDLE  = 3'd0;
  localparam logic [2:0] STAGE_PRD   = 3'd1;
  localparam logic [2:0] STAGE_NEW   = 3'd2;
  localparam logic [2:0] STAGE_UPD   = 3'd3;
  localparam logic [2:0] STAGE_ASSOC = 3'd4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  function automatic logic is_legal_stage(
    input logic [2:0] code
  );
    return (code >= STAGE_PRD) &&
           (code <= STAGE_ASSOC);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: registered first-word fall-through FIFO
// with occupancy count; head entry is always on rdata.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 67
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/stage_cmd_seq.sv
// stage_cmd_seq: replays buffered stage commands on
// stage_val/stage_rdy. Optional watchdog: CMD_TIMEOUT_EN.
module stage_cmd_seq
  import ekf_stage_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DW        = 32,
  parameter int GUARD_CYC = 2,
  parameter int TMO_CYC   = 1 << 20
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_stage,
  input  logic [DW-1:0]            cmd_op0,
  input  logic [DW-1:0]            cmd_op1,
  output logic [2:0]               stage_val,
  input  logic                     stage_rdy,
  output logic [DW-1:0]            vlr,
  output logic [DW-1:0]            alpha,
  output logic [DW-1:0]            rk,
  output logic [DW-1:0]            phi,
  output logic                     done_valid,
  output logic [2:0]               done_stage,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_illegal,
  output logic                     err_timeout
);

  localparam int W  = 3 + 2 * DW;
  localparam int GW = (GUARD_CYC > 1) ?
                      $clog2(GUARD_CYC) : 1;

  logic [2:0]    state;
  logic [GW-1:0] guard_cnt;
  logic          cmd_legal;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [W-1:0]  head;
  logic [2:0]    h_stage;
  logic [DW-1:0] h_op0;
  logic [DW-1:0] h_op1;
  logic          tmo_hit;
  logic          finish;

  assign cmd_legal = is_legal_stage(cmd_stage);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready & cmd_legal;
  assign pop       = (state == S_IDLE) & ~empty;

  assign h_stage = head[W-1 -: 3];
  assign h_op0   = head[2*DW-1 -: DW];
  assign h_op1   = head[DW-1:0];

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .sys_rst (sys_rst),
    .push    (push),
    .wdata   ({cmd_stage, cmd_op0, cmd_op1}),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_level)
  );

  assign finish     = (state == S_WAIT) &
                      (stage_rdy | tmo_hit);
  assign done_valid = finish;
  assign done_stage = finish ? stage_val : STAGE_IDLE;
  assign busy       = (state != S_IDLE) | ~empty;

  // stage FSM; operands load on the pop edge so they are
  // already settled in the first cycle stage_val is nonzero
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      stage_val <= STAGE_IDLE;
      guard_cnt <= '0;
      vlr       <= '0;
      alpha     <= '0;
      rk        <= '0;
      phi       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            stage_val <= h_stage;
            if (h_stage == STAGE_PRD) begin
              vlr   <= h_op0;
              alpha <= h_op1;
            end else begin
              rk  <= h_op0;
              phi <= h_op1;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          guard_cnt <= GW'(GUARD_CYC - 1);
          state     <= S_GUARD;
        end
        S_GUARD: begin
          if (guard_cnt == '0) state <= S_WAIT;
          else guard_cnt <= guard_cnt - 1'b1;
        end
        S_WAIT: begin
          if (finish) begin
            stage_val <= STAGE_IDLE;
            state     <= S_GAP;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // sticky flag for discarded illegal stage codes
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) err_illegal <= 1'b0;
    else if (cmd_valid & cmd_ready & ~cmd_legal)
      err_illegal <= 1'b1;
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 1) ?
                      $clog2(TMO_CYC) : 1;

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == S_WAIT) & ~stage_rdy &
                   (tmo_cnt == TW'(TMO_CYC - 1));

  // watchdog on time spent in S_WAIT
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state != S_WAIT) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stage_cmd_seq.sv
// tb_stage_cmd_seq: scoreboard bench for stage_cmd_seq.
// Issue order/operands and done codes checked by monitor.
module tb_stage_cmd_seq;
  import ekf_stage_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int GC    = 2;
`ifdef CMD_TIMEOUT_EN
  localparam int TMO   = 16;
`else
  localparam int TMO   = 1 << 20;
`endif

  logic          clk;
  logic          sys_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_stage;
  logic [DW-1:0] cmd_op0;
  logic [DW-1:0] cmd_op1;
  logic [2:0]    stage_val;
  logic          stage_rdy;
  logic [DW-1:0] vlr;
  logic [DW-1:0] alpha;
  logic [DW-1:0] rk;
  logic [DW-1:0] phi;
  logic          done_valid;
  logic [2:0]    done_stage;
  logic          busy;
  logic [2:0]    fifo_level;
  logic          err_illegal;
  logic          err_timeout;

  typedef struct packed {
    logic [2:0]    st;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] done_q[$];
  int         n_chk;
  int         n_err;

  stage_cmd_seq #(
    .DEPTH     (DEPTH),
    .DW        (DW),
    .GUARD_CYC (GC),
    .TMO_CYC   (TMO)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_stage   (cmd_stage),
    .cmd_op0     (cmd_op0),
    .cmd_op1     (cmd_op1),
    .stage_val   (stage_val),
    .stage_rdy   (stage_rdy),
    .vlr         (vlr),
    .alpha       (alpha),
    .rk          (rk),
    .phi         (phi),
    .done_valid  (done_valid),
    .done_stage  (done_stage),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  logic [2:0]    prev_sv;
  logic [DW-1:0] m_vlr, m_alpha, m_rk, m_phi;
  exp_t          e;

  // monitor: issue order, operand values, hold, done
  always @(negedge clk) begin
    if (sys_rst) begin
      prev_sv = 3'd0;
      m_vlr   = '0;
      m_alpha = '0;
      m_rk    = '0;
      m_phi   = '0;
    end else begin
      if (stage_val != 3'd0 && prev_sv == 3'd0) begin
        if (exp_q.size() == 0)
          chk("unexpected_issue", stage_val, 0);
        else begin
          e = exp_q.pop_front();
          chk("issue_stage", stage_val, e.st);
          if (e.st == STAGE_PRD) begin
            m_vlr   = e.a;
            m_alpha = e.b;
          end else begin
            m_rk  = e.a;
            m_phi = e.b;
          end
          done_q.push_back(e.st);
        end
      end else if (stage_val != 3'd0) begin
        chk("stage_hold", stage_val, prev_sv);
      end
      if (stage_val != 3'd0) begin
        chk("op_vlr", vlr, m_vlr);
        chk("op_alpha", alpha, m_alpha);
        chk("op_rk", rk, m_rk);
        chk("op_phi", phi, m_phi);
      end
      if (done_valid) begin
        if (done_q.size() == 0)
          chk("unexpected_done", done_valid, 0);
        else
          chk("done_stage", done_stage,
              done_q.pop_front());
      end
      prev_sv = stage_val;
    end
  end

  task automatic push(
    input  logic [2:0]    st,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output bit            acc
  );
    exp_t x;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_stage = st;
    cmd_op0   = a;
    cmd_op1   = b;
    acc       = cmd_ready;
    @(posedge clk);
    if (acc && is_legal_stage(st)) begin
      x.st = st;
      x.a  = a;
      x.b  = b;
      exp_q.push_back(x);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy && stage_val == 3'd0 &&
          exp_q.size() == 0) break;
    end
    chk("idle_busy", busy, 0);
  endtask

  task automatic wait_issue(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (stage_val != 3'd0) break;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (done_valid) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit         acc;
    int         n;
    logic [2:0] codes [5];
    codes[0] = STAGE_PRD;
    codes[1] = STAGE_NEW;
    codes[2] = STAGE_UPD;
    codes[3] = STAGE_ASSOC;
    codes[4] = STAGE_PRD;
    n_chk     = 0;
    n_err     = 0;
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_stage = 3'd0;
    cmd_op0   = '0;
    cmd_op1   = '0;
    stage_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stage_val", stage_val, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_illegal", err_illegal, 0);
    chk("rst_timeout", err_timeout, 0);
    chk("rst_vlr", vlr, 0);
    sys_rst = 1'b0;

    // predict command, issue latency and operands
    push(STAGE_PRD, 32'h0001_0000, 32'h0000_8000, acc);
    chk("t1_acc", acc, 1);
    @(negedge clk);
    chk("t1_lat_early", stage_val, 0);
    chk("t1_level", fifo_level, 1);
    @(negedge clk);
    chk("t1_stage", stage_val, STAGE_PRD);
    chk("t1_vlr", vlr, 32'h0001_0000);
    chk("t1_alpha", alpha, 32'h0000_8000);
    chk("t1_rk", rk, 0);
    chk("t1_phi", phi, 0);
    repeat (5) @(negedge clk);
    chk("t1_wait_hold", stage_val, STAGE_PRD);
    stage_rdy = 1'b1;
    wait_idle(50);

    // guard window with stage_rdy already high
    push(STAGE_UPD, 32'd5, 32'd7, acc);
    wait_issue(n);
    chk("t2_issue_lat", n, 2);
    chk("t2_no_early_done", done_valid, 0);
    chk("t2_rk", rk, 5);
    chk("t2_phi", phi, 7);
    chk("t2_vlr_kept", vlr, 32'h0001_0000);
    wait_done(n);
    chk("t2_done_lat", n, GC + 1);
    @(negedge clk);
    chk("t2_gap_stage", stage_val, 0);
    chk("t2_gap_done", done_valid, 0);
    stage_rdy = 1'b0;
    wait_idle(50);

    // fill to full, refuse a sixth, drain in order
    for (int i = 0; i < 5; i++) begin
      push(codes[i], 32'h100 + i, 32'hF000 - i, acc);
      chk("t3_acc", acc, 1);
    end
    @(negedge clk);
    chk("t3_level_full", fifo_level, 4);
    chk("t3_ready_low", cmd_ready, 0);
    push(STAGE_NEW, 32'hDEAD, 32'hBEEF, acc);
    chk("t3_refused", acc, 0);
    @(negedge clk);
    chk("t3_level_kept", fifo_level, 4);
    stage_rdy = 1'b1;
    wait_idle(200);
    stage_rdy = 1'b0;

    // illegal code is swallowed
    push(3'd6, 32'h1, 32'h2, acc);
    chk("t4_acc", acc, 1);
    @(negedge clk);
    chk("t4_illegal", err_illegal, 1);
    chk("t4_level", fifo_level, 0);
    repeat (3) @(negedge clk);
    chk("t4_stage", stage_val, 0);
    chk("t4_busy", busy, 0);

    // reset in the middle of an ASSOC wait
    push(STAGE_ASSOC, 32'hA5A5_A5A5, 32'h5A5A_5A5A, acc);
    push(STAGE_NEW, 32'd1, 32'd2, acc);
    push(STAGE_UPD, 32'd3, 32'd4, acc);
    repeat (4) @(negedge clk);
    chk("t5_pre_stage", stage_val, STAGE_ASSOC);
    chk("t5_pre_level", fifo_level, 2);
    #2 sys_rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    #1;
    chk("t5_stage", stage_val, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_rk", rk, 0);
    chk("t5_phi", phi, 0);
    chk("t5_vlr", vlr, 0);
    chk("t5_alpha", alpha, 0);
    chk("t5_illegal", err_illegal, 0);
    repeat (2) @(negedge clk);
    #2 sys_rst = 1'b0;

`ifdef CMD_TIMEOUT_EN
    // watchdog releases a stuck NEW stage
    push(STAGE_NEW, 32'd11, 32'd22, acc);
    wait_issue(n);
    chk("t6_issue_lat", n, 2);
    wait_done(n);
    chk("t6_tmo_lat", n, GC + TMO);
    chk("t6_tmo_before", err_timeout, 0);
    @(negedge clk);
    chk("t6_tmo_flag", err_timeout, 1);
    chk("t6_gap_stage", stage_val, 0);
    wait_idle(50);
`else
    chk("t6_tmo_tied", err_timeout, 0);
`endif

    chk("end_exp_q", exp_q.size(), 0);
    chk("end_done_q", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
